// File: rtl/dm_sized.sv
// dm_sized: byte/halfword/word data memory for the MEM stage.
// Little-endian, valid/ready request handshake, one-cycle registered response.
// After reset release an optional clear sequencer zeroes one word per cycle,
// holding req_ready low until the whole array has been written.
//
// Ports:
//   clk          clock, all state changes on posedge
//   reset        asynchronous active-low reset
//   req_valid    request present
//   req_ready    block can accept a request this cycle
//   req_write    1 store, 0 load
//   req_size     00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned loads only: 1 zero-extend, 0 sign-extend
//   req_addr     byte address; bits above ADDR_WIDTH-1 alias
//   req_wdata    store data, low 8/16/32 bits used
//   resp_valid   one-cycle pulse for the request accepted on the previous edge
//   resp_rdata   extended load data; 0 for stores and errors
//   resp_err     request was misaligned or illegal
module dm_sized #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned WORD_AW  = ADDR_WIDTH - 2;
    localparam int unsigned MEM_SIZE = 1 << WORD_AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_e               state_q, state_d;
    logic [WORD_AW-1:0]   clr_idx_q, clr_idx_d;
    logic                 ready_q, ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic                 resp_err_q, resp_err_d;

    logic [31:0]          mem_q [MEM_SIZE];

    logic                 mem_we_c;
    logic [WORD_AW-1:0]   mem_waddr_c;
    logic [31:0]          mem_wdata_c;
    logic [3:0]           mem_be_c;

    logic [WORD_AW-1:0]   word_idx_c;
    logic                 err_c;
    logic [31:0]          rd_word_c;
    logic [7:0]           rd_byte_c;
    logic [15:0]          rd_half_c;
    logic [31:0]          load_c;
    logic [31:0]          st_wdata_c;
    logic [3:0]           st_be_c;
    logic                 accept_c;

    // Upper address bits alias and are intentionally ignored.
    logic unused_addr_c;
    assign unused_addr_c = ^req_addr[31:ADDR_WIDTH];

    // Request decode: alignment check, load lane extraction, store lane steering.
    always_comb begin
        word_idx_c = req_addr[ADDR_WIDTH-1:2];
        rd_word_c  = mem_q[word_idx_c];
        rd_byte_c  = rd_word_c[{req_addr[1:0], 3'b000} +: 8];
        rd_half_c  = req_addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];

        err_c      = 1'b0;
        load_c     = rd_word_c;
        st_wdata_c = req_wdata;
        st_be_c    = 4'b1111;
        case (req_size)
            2'b00: begin
                load_c     = {{24{rd_byte_c[7] & ~req_unsigned}}, rd_byte_c};
                st_wdata_c = {4{req_wdata[7:0]}};
                st_be_c    = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                err_c      = req_addr[0];
                load_c     = {{16{rd_half_c[15] & ~req_unsigned}}, rd_half_c};
                st_wdata_c = {2{req_wdata[15:0]}};
                st_be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                err_c = |req_addr[1:0];
            end
            default: begin
                err_c = 1'b1;
            end
        endcase
    end

    // Next-state, memory write port and response generation.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        accept_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_waddr_c  = clr_idx_q;
        mem_wdata_c  = 32'h0;
        mem_be_c     = 4'b1111;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c  = 1'b1;
                clr_idx_d = clr_idx_q + WORD_AW'(1);
                if (clr_idx_q == WORD_AW'(MEM_SIZE - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                accept_c = req_valid && ready_q;
                if (accept_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_c;
                    resp_rdata_d = (err_c || req_write) ? 32'h0 : load_c;
                    if (!err_c && req_write) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = word_idx_c;
                        mem_wdata_c = st_wdata_c;
                        mem_be_c    = st_be_c;
                    end
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        ready_d = (state_d == ST_READY);
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RST_STATE;
            clr_idx_q    <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array: never reset, zeroed by the clear sequencer instead.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be_c[i]) begin
                    mem_q[mem_waddr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
module tb_dm_sized;

    localparam int unsigned AW       = 12;
    localparam int unsigned MEM_SIZE = 1 << (AW - 2);
    localparam int unsigned NBYTES   = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dm_sized #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  ref_mem [NBYTES];
    int          cyc;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance and the expected response.
    task automatic step(input logic v, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        logic        rdy, acc, err;
        logic [31:0] rd;
        int          b, nb;
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        rdy = (cyc >= int'(MEM_SIZE));
        check("req_ready", 32'(req_ready), 32'(rdy));
        acc = v && rdy;
        b   = int'(a[AW-1:0]);
        nb  = 1 << int'(sz);
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        rd  = 32'h0;
        if (acc && !err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[b+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[b+i];
                if (!u && sz == 2'b00) rd = {{24{rd[7]}}, rd[7:0]};
                if (!u && sz == 2'b01) rd = {{16{rd[15]}}, rd[15:0]};
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check("resp_valid", 32'(resp_valid), 32'(acc));
        if (acc) begin
            last_rdata = rd;
            last_err   = err;
        end
        check("resp_rdata", resp_rdata, last_rdata);
        check("resp_err", 32'(resp_err), 32'(last_err));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rand_step(input bit allow_idle);
        logic v;
        v = allow_idle ? ($urandom_range(0, 3) != 0) : 1'b1;
        step(v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom & 32'hF000_003F, $urandom);
    endtask

    // Called #1 after a posedge; asserts reset for n edges and checks reset values.
    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(resp_valid), 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'h0);
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;
        last_rdata = 32'h0;
        last_err   = 1'b0;
        cyc        = 0;
        reset      = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        cyc = 0; last_rdata = 32'h0; last_err = 1'b0;
        @(posedge clk);
        #1;

        // Clear sequence: ready low for exactly MEM_SIZE cycles, random requests ignored.
        do_reset(3);
        while (cyc < int'(MEM_SIZE)) rand_step(1'b1);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0);
        check("clear_ffc", resp_rdata, 32'h0);

        // Store merge.
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        step(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        step(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
        idle();
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("merge_lw", resp_rdata, 32'hBEEF_AB44);

        // Extension.
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F80);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        check("lb", resp_rdata, 32'hFFFF_FF80);
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        check("lbu", resp_rdata, 32'h0000_0080);
        step(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lh", resp_rdata, 32'hFFFF_80FF);
        step(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("lhu", resp_rdata, 32'h0000_80FF);

        // Misalignment and illegal size.
        step(1'b1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_1234);
        check("sh_mis_err", 32'(resp_err), 32'h1);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        check("lw_mis_err", 32'(resp_err), 32'h1);
        check("lw_mis_data", resp_rdata, 32'h0);
        step(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        check("size3_err", 32'(resp_err), 32'h1);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("after_err_lw", resp_rdata, 32'h80FF_7F80);
        check("after_err_ok", 32'(resp_err), 32'h0);

        // Back-to-back with aliasing, valid held high.
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFE_F00D);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);
        check("b2b_alias", resp_rdata, 32'hCAFE_F00D);

        // Randomized traffic over a small aliased window.
        repeat (400) rand_step(1'b1);

        // Reset with a response pending, then reset again mid-clear.
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
        do_reset(1);
        repeat (500) rand_step(1'b1);
        do_reset(2);
        while (cyc < int'(MEM_SIZE)) rand_step(1'b0);

        // Array is zero again after the full clear.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
        step(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0);
        check("clear2_ffc", resp_rdata, 32'h0);
        repeat (200) rand_step(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
